// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared types and defaults for the writeback arbiter
// Contents: word_t / reg_sel scalar types, wb_req_t {rd, data} FIFO payload,
// default NUM_SRC / FIFO_DEPTH values, reg_onehot() decode helper.
package wb_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int REG_W    = 5;
    localparam int NUM_REGS = 2 ** REG_W;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [REG_W-1:0] reg_sel;

    typedef struct packed {
        reg_sel rd;
        word_t  data;
    } wb_req_t;

    localparam int WB_NUM_SRC_DEF    = 3;
    localparam int WB_FIFO_DEPTH_DEF = 4;

    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_sel r);
        logic [NUM_REGS-1:0] m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - producer handshake and register-file write port bundle
// master: arbiter side (drives src_ready, wen/wsel/wdat, pending, fifo flags)
// slave : environment side (drives src_valid/src_rd/src_data, wb_stall)
interface wb_arbiter_if #(
    parameter int NUM_SRC = wb_arbiter_pkg::WB_NUM_SRC_DEF
);
    import wb_arbiter_pkg::*;

    logic [NUM_SRC-1:0]  src_valid;
    reg_sel [NUM_SRC-1:0] src_rd;
    word_t  [NUM_SRC-1:0] src_data;
    logic [NUM_SRC-1:0]  src_ready;
    logic                wb_stall;
    logic                wen;
    reg_sel              wsel;
    word_t               wdat;
    logic [NUM_REGS-1:0] pending;
    logic                fifo_full;
    logic                fifo_empty;

    modport master (
        input  src_valid, src_rd, src_data, wb_stall,
        output src_ready, wen, wsel, wdat, pending, fifo_full, fifo_empty
    );

    modport slave (
        output src_valid, src_rd, src_data, wb_stall,
        input  src_ready, wen, wsel, wdat, pending, fifo_full, fifo_empty
    );

endinterface

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - synchronous FIFO of wb_req_t with per-entry valid export
// Ports: clk, rst (async active-high); push/push_data, pop; head (registered
// storage at read pointer), count, full, empty; entry_valid/entries expose
// the whole storage so the parent can build a pending-destination mask.
// Caller guarantees no pop when empty and no push when full without pop.
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = WB_FIFO_DEPTH_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_req_t               push_data,
    input  logic                  pop,
    output wb_req_t               head,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH-1:0]      entry_valid,
    output wb_req_t [DEPTH-1:0]   entries
);

    wb_req_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pop before push: when full, both target the same slot and the
        // newly written entry must remain valid.
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q]   = push_data;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign count       = count_q;
    assign full        = (count_q == CNT_W'(DEPTH));
    assign empty       = (count_q == '0);
    assign entry_valid = valid_q;
    assign entries     = mem_q;

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter feeding the register file port
// Ports: clk, rst (async active-high); bus (wb_arbiter_if.master):
//   src_valid/src_rd/src_data in, src_ready one-hot grant out, wb_stall in,
//   wen/wsel/wdat write port out, pending mask, fifo_full/fifo_empty.
// Optional: WB_BYPASS_EN - when the FIFO is empty and not stalled, a granted
// non-x0 write goes straight to the write port in the same cycle.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = WB_NUM_SRC_DEF,
    parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEF
) (
    input  logic           clk,
    input  logic           rst,
    wb_arbiter_if.master   bus
);

    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int IDX_W1 = IDX_W + 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [IDX_W:0] NUM_SRC_W = IDX_W1'(NUM_SRC);

    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W:0]   cand;
    logic             found;
    logic             pop, space, transfer, push, bypass;
    wb_req_t          grant_req;

    wb_req_t                   head;
    logic [CNT_W-1:0]          count;
    logic                      full, empty;
    logic [FIFO_DEPTH-1:0]     entry_valid;
    wb_req_t [FIFO_DEPTH-1:0]  entries;
    logic [NUM_REGS-1:0]       pend;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (grant_req),
        .pop         (pop),
        .head        (head),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_ptr_q} + IDX_W1'(k);
            if (cand >= NUM_SRC_W) begin
                cand = cand - NUM_SRC_W;
            end
            if (!found && bus.src_valid[cand[IDX_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        pop      = !empty && !bus.wb_stall;
        // A pop this cycle frees a slot, so a full FIFO can still accept.
        space    = (count < CNT_W'(FIFO_DEPTH)) || pop;
        transfer = !rst && space && found;

        grant_req.rd   = bus.src_rd[grant_idx];
        grant_req.data = bus.src_data[grant_idx];

`ifdef WB_BYPASS_EN
        bypass = transfer && (grant_req.rd != '0) && empty && !bus.wb_stall;
`else
        bypass = 1'b0;
`endif
        // x0 writes are acknowledged but never stored or issued.
        push = transfer && (grant_req.rd != '0) && !bypass;

        bus.src_ready = '0;
        if (transfer) begin
            bus.src_ready[grant_idx] = 1'b1;
        end

        rr_ptr_d = rr_ptr_q;
        if (transfer) begin
            if (grant_idx == IDX_W'(NUM_SRC - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + IDX_W'(1);
            end
        end
    end

    // Write port: FIFO head has priority; bypass only possible when empty.
    always_comb begin
        bus.wen  = 1'b0;
        bus.wsel = '0;
        bus.wdat = '0;
        if (pop) begin
            bus.wen  = 1'b1;
            bus.wsel = head.rd;
            bus.wdat = head.data;
        end else if (bypass) begin
            bus.wen  = 1'b1;
            bus.wsel = grant_req.rd;
            bus.wdat = grant_req.data;
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pend = pend | reg_onehot(entries[i].rd);
            end
        end
        pend[0]     = 1'b0;
        bus.pending = pend;
    end

    assign bus.fifo_full  = full;
    assign bus.fifo_empty = empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter (queue model + directed vectors)
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int N     = 3;
    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    wb_arbiter_if #(.NUM_SRC(N)) bus ();

    wb_arbiter #(.NUM_SRC(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: a queue of accepted writes plus a round-robin pointer.
    wb_req_t mq[$];
    int      mrr = 0;

    always @(negedge clk) begin : model_cmp
        logic          e_pop, e_space, e_byp, e_wen;
        int            g;
        logic [N-1:0]  e_ready;
        logic [4:0]    e_wsel;
        logic [31:0]   e_wdat, e_pend;
        wb_req_t       r;
        if (rst) begin
            mq.delete();
            mrr = 0;
            check("m_rst_ready", bus.src_ready, 0);
            check("m_rst_wen", bus.wen, 0);
            check("m_rst_pending", bus.pending, 0);
            check("m_rst_empty", bus.fifo_empty, 1);
            check("m_rst_full", bus.fifo_full, 0);
        end else begin
            e_pop   = (mq.size() > 0) && !bus.wb_stall;
            e_space = (mq.size() < DEPTH) || e_pop;
            g = -1;
            if (e_space) begin
                for (int k = 0; k < N; k++) begin
                    if (g < 0 && bus.src_valid[(mrr + k) % N]) g = (mrr + k) % N;
                end
            end
            e_ready = '0;
            r = '0;
            if (g >= 0) begin
                e_ready[g] = 1'b1;
                r.rd   = bus.src_rd[g];
                r.data = bus.src_data[g];
            end
            e_byp = (LAT == 0) && (g >= 0) && (mq.size() == 0) && !bus.wb_stall && (r.rd != 0);
            e_wen = 0; e_wsel = 0; e_wdat = 0;
            if (e_pop) begin
                e_wen = 1; e_wsel = mq[0].rd; e_wdat = mq[0].data;
            end else if (e_byp) begin
                e_wen = 1; e_wsel = r.rd; e_wdat = r.data;
            end
            e_pend = 0;
            foreach (mq[i]) e_pend = e_pend | (32'h1 << mq[i].rd);
            e_pend[0] = 1'b0;
            check("m_ready", bus.src_ready, e_ready);
            check("m_wen", bus.wen, e_wen);
            check("m_wsel", bus.wsel, e_wsel);
            check("m_wdat", bus.wdat, e_wdat);
            check("m_pending", bus.pending, e_pend);
            check("m_full", bus.fifo_full, mq.size() == DEPTH);
            check("m_empty", bus.fifo_empty, mq.size() == 0);
            if (e_pop) void'(mq.pop_front());
            if (g >= 0) begin
                mrr = (g + 1) % N;
                if (r.rd != 0 && !e_byp) mq.push_back(r);
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        bus.src_valid = '0;
        bus.wb_stall  = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bus.src_valid = '0;
        bus.src_rd    = '0;
        bus.src_data  = '0;
        bus.wb_stall  = 1'b0;
        #2;
        check("rst_wen", bus.wen, 0);
        check("rst_pending", bus.pending, 0);
        check("rst_empty", bus.fifo_empty, 1);
        check("rst_full", bus.fifo_full, 0);
        check("rst_wsel", bus.wsel, 0);
        next_cyc();
        rst = 1'b0;

        // Single write
        do_reset();
        bus.src_valid = 3'b001; bus.src_rd[0] = 5; bus.src_data[0] = 32'hDEADBEEF;
        #1;
        check("single_ready", bus.src_ready, 3'b001);
        check("single_wen0", bus.wen, (LAT == 0) ? 1 : 0);
        check("single_wsel0", bus.wsel, (LAT == 0) ? 5 : 0);
        next_cyc();
        bus.src_valid = '0;
        #1;
        check("single_wen1", bus.wen, (LAT == 1) ? 1 : 0);
        check("single_wsel1", bus.wsel, (LAT == 1) ? 5 : 0);
        check("single_wdat1", bus.wdat, (LAT == 1) ? 32'hDEADBEEF : 0);
        next_cyc();

        // Round-robin with all sources valid
        do_reset();
        for (int i = 0; i < N; i++) begin
            bus.src_rd[i]   = reg_sel'(i + 1);
            bus.src_data[i] = 32'h100 + i;
        end
        bus.src_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", bus.src_ready, 32'h1 << (k % 3));
            check("rr_wsel", bus.wsel, (k >= LAT) ? ((k - LAT) % 3) + 1 : 0);
            next_cyc();
        end
        bus.src_valid = '0;
        next_cyc();
        next_cyc();

        // Full with stall, then release
        do_reset();
        bus.wb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.src_valid = 3'b001; bus.src_rd[0] = reg_sel'(7 + k); bus.src_data[0] = 32'h70 + k;
            #1;
            check("full_accept", bus.src_ready, 3'b001);
            next_cyc();
        end
        bus.src_rd[0] = 11; bus.src_data[0] = 32'h7B;
        #1;
        check("full_ready", bus.src_ready, 0);
        check("full_flag", bus.fifo_full, 1);
        check("full_pending", bus.pending, 32'h0000_0780);
        next_cyc();
        bus.wb_stall = 1'b0;
        #1;
        check("full_pushpop_ready", bus.src_ready, 3'b001);
        check("full_wen", bus.wen, 1);
        check("full_wsel7", bus.wsel, 7);
        next_cyc();
        bus.src_valid = '0;
        for (int j = 0; j < 4; j++) begin
            #1;
            check("full_order", bus.wsel, 8 + j);
            next_cyc();
        end
        #1;
        check("full_drained", bus.wen, 0);
        next_cyc();

        // x0 drop and rr_ptr advance
        do_reset();
        bus.src_valid = 3'b010; bus.src_rd[1] = 0; bus.src_data[1] = 32'h1234;
        #1;
        check("x0_ready", bus.src_ready, 3'b010);
        check("x0_wen", bus.wen, 0);
        next_cyc();
        bus.src_valid = 3'b101;
        bus.src_rd[0] = 6; bus.src_data[0] = 32'h66;
        bus.src_rd[2] = 9; bus.src_data[2] = 32'h99;
        #1;
        check("x0_rr_ready", bus.src_ready, 3'b100);
        check("x0_pending", bus.pending, 0);
        next_cyc();
        bus.src_valid = 3'b001;
        #1;
        check("x0_next_ready", bus.src_ready, 3'b001);
        check("x0_next_wsel", bus.wsel, (LAT == 1) ? 9 : 6);
        next_cyc();
        bus.src_valid = '0;
        next_cyc();
        next_cyc();

        // Same-rd ordering under stall
        do_reset();
        bus.wb_stall = 1'b1;
        bus.src_valid = 3'b001; bus.src_rd[0] = 4; bus.src_data[0] = 32'h1;
        #1;
        check("same_acc1", bus.src_ready, 3'b001);
        next_cyc();
        bus.src_data[0] = 32'h2;
        #1;
        check("same_acc2", bus.src_ready, 3'b001);
        next_cyc();
        bus.src_valid = '0;
        #1;
        check("same_pend", bus.pending, 32'h10);
        next_cyc();
        bus.wb_stall = 1'b0;
        #1;
        check("same_wdat1", bus.wdat, 32'h1);
        check("same_pend1", bus.pending, 32'h10);
        next_cyc();
        #1;
        check("same_wdat2", bus.wdat, 32'h2);
        check("same_pend2", bus.pending, 32'h10);
        next_cyc();
        #1;
        check("same_wen_end", bus.wen, 0);
        check("same_pend_end", bus.pending, 0);
        next_cyc();

        // Reset mid-stream
        do_reset();
        bus.wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.src_valid = 3'b001; bus.src_rd[0] = reg_sel'(12 + k); bus.src_data[0] = 32'hC0 + k;
            next_cyc();
        end
        bus.src_valid = '0;
        #1;
        check("mid_pend_before", bus.pending, 32'h0000_7000);
        #1 rst = 1'b1;
        #1;
        check("mid_wen", bus.wen, 0);
        check("mid_pending", bus.pending, 0);
        check("mid_empty", bus.fifo_empty, 1);
        bus.wb_stall = 1'b0;
        next_cyc();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("mid_no_write", bus.wen, 0);
            next_cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Initiator for the register file write port: collects writeback requests from NUM_SRC producers (ALU, load unit, mul/div) over valid/ready handshakes.
- Arbitrates round-robin and buffers accepted writes in a small FIFO.
- Issues at most one write per cycle on wen/wsel/wdat.
- Exports a pending-destination mask for hazard logic.

Parameters:
- NUM_SRC, 3, number of writeback producers (2..8)
- FIFO_DEPTH, 4, buffered writes (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- src_valid  in  NUM_SRC  producer i has a write request
- src_rd  in  NUM_SRC x REG_W  destination register per producer
- src_data  in  NUM_SRC x 32  write data per producer (word_t)
- src_ready  out  NUM_SRC  one-hot grant; transfer when valid&&ready
- wb_stall  in  1  register file port unavailable this cycle; no pop
- wen  out  1  register file write enable
- wsel  out  REG_W  register file write select
- wdat  out  32  register file write data
- pending  out  2**REG_W  bit r set while a write to r is buffered
- fifo_full  out  1  count == FIFO_DEPTH
- fifo_empty  out  1  count == 0

Behaviour:
- Reset (async, rst=1): FIFO count/pointers=0, rr_ptr=0. Outputs: wen=0, wsel=0, wdat=0, pending=0, src_ready=0, fifo_empty=1, fifo_full=0. Buffered entries are discarded on reset mid-operation.
- pop = !fifo_empty && !wb_stall.
- Output port:
  - wen=pop; wsel/wdat = FIFO head when pop, else 0.
  - Combinational from registered head storage.
- Accept condition: space = (count < FIFO_DEPTH) || pop. Simultaneous push and pop when full is legal.
- Grant:
  - If space, src_ready is one-hot on the first valid source searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC; otherwise src_ready=0.
  - src_ready never asserts for a non-valid source.
  - At most one transfer per cycle.
- rr_ptr update: after a transfer from source i, rr_ptr <= (i+1) mod NUM_SRC. Otherwise unchanged.
- x0 handling: a transfer with src_rd==0 is accepted (ready high, rr_ptr advances) but not enqueued. It never produces wen.
- Latency: a write accepted in cycle N appears on wen in cycle N+1 at earliest. It is committed to the register file at the end of that cycle. Each wb_stall cycle adds one.
- Ordering: writes leave in acceptance order. Two buffered writes to the same rd both issue, so the later one wins.
- pending:
  - OR over valid FIFO entries of one-hot(rd).
  - Bit clears in the cycle after the last matching entry pops.
  - pending[0] is always 0.
- Counter: count' = count + push − pop. Pointers wrap modulo FIFO_DEPTH.
- Producers must hold valid, rd and data stable until ready. The block does not check this.

Optional Feature:
- WB_BYPASS_EN defined:
  - When fifo_empty && !wb_stall && a transfer with rd!=0 occurs, drive wen=1, wsel=src_rd[i], wdat=src_data[i] in the same cycle.
  - The bypassed write is not enqueued and pending is unaffected, giving zero-cycle latency.
- Undefined: every non-x0 transfer is enqueued; minimum latency is 1 cycle.

Decomposition:
- rv32ima_pkg additions:
  - wb_req_t packed struct {reg_sel rd; word_t data}
  - WB_NUM_SRC_DEF = 3, WB_FIFO_DEPTH_DEF = 4
- Reused from the package: word_t, REG_W.
- Sub-module: wb_fifo.
  - Parameterised synchronous FIFO of wb_req_t, async active-high reset.
  - Ports: push, pop, head, count, full, empty, plus an entry-valid vector and an entry array for building pending.
- Round-robin grant logic stays in wb_arbiter.

Test Plan:
- Reset mid-stream: 3 entries buffered, wb_stall=1, pulse rst -> wen=0, pending=0, fifo_empty=1 immediately (async), no write ever issues.
- Single write: src0 valid rd=5 data=0xDEADBEEF at cycle 0 -> src_ready[0]=1 at cycle 0; wen=1, wsel=5, wdat=0xDEADBEEF at cycle 1 (cycle 0 with WB_BYPASS_EN).
- Round-robin: all three sources valid continuously (rd 1/2/3) -> grants in order 0,1,2,0,1,2; wsel sequence 1,2,3,1,2,3 one cycle later.
- Full with stall: wb_stall=1 and src0 streaming rd=7..10 -> 4 accepts, then fifo_full=1, src_ready=0, pending bits 7..10 set; release stall -> ready reasserts the same cycle (push+pop), writes issue 7,8,9,10 in order.
- x0 drop: src1 rd=0 data=0x1234 -> src_ready[1]=1, rr_ptr advances to 2, no wen ever, pending unchanged.
- Same-rd ordering: rd=4 data=0x1 then rd=4 data=0x2 under stall -> pending[4]=1 until both pop; wdat sequence 0x1 then 0x2.
